imem_loader: RTL

// - Boot-time program loader upstream of the cpu. Receives a byte stream over a valid/ready

---
 rtl/imem_loader.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Boot-time loader: assembles a byte stream into 32-bit words and writes them into the cpu.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
   parameter logic [31:0] BASE_ADDR = 32'd0,
   parameter int unsigned MAX_WORDS = 256
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   input  logic [7:0]  in_data_i,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   output logic        initialize_o,
   output logic        cpu_rst_o,
   output logic [31:0] instruction_initialize_address_o,
   output logic [31:0] instruction_initialize_data_o,
   output logic        init_we_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        error_o
);

   typedef enum logic [2:0] {StIdle, StCnt, StData, StWr, StRun, StErr, StChk} state_e;

`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam state_e PostLoadSt = StChk;
`else
   localparam state_e PostLoadSt = StRun;
`endif

   state_e      state_q, state_d;
   logic [15:0] n_q, n_d;
   logic [15:0] idx_q, idx_d;
   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic [23:0] word_q, word_d;
   logic [7:0]  csum_q, csum_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] data_q, data_d;

   logic        fire;
   logic [15:0] n_new;
   logic [16:0] idx_inc;

   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      idx_d      = idx_q;
      byte_cnt_d = byte_cnt_q;
      word_d     = word_q;
      csum_d     = csum_q;
      addr_d     = addr_q;
      data_d     = data_q;

      in_ready_o = (state_q == StCnt) || (state_q == StData) || (state_q == StChk);
      fire       = in_valid_i && in_ready_o;
      n_new      = {n_q[15:8], in_data_i};
      idx_inc    = {1'b0, idx_q} + 17'd1;

      unique case (state_q)
         StIdle, StRun, StErr: begin
            if (start_i) begin
               state_d    = StCnt;
               idx_d      = '0;
               byte_cnt_d = '0;
               csum_d     = '0;
            end
         end
         StCnt: begin
            if (fire) begin
               if (byte_cnt_q == 2'd0) begin
                  n_d[15:8]  = in_data_i;
                  byte_cnt_d = 2'd1;
               end else begin
                  n_d        = n_new;
                  byte_cnt_d = 2'd0;
                  if (n_new == 16'd0) begin
                     state_d = PostLoadSt;
                  end else if ({16'd0, n_new} > MAX_WORDS) begin
                     state_d = StErr;
                  end else begin
                     state_d = StData;
                  end
               end
            end
         end
         StData: begin
            if (fire) begin
               word_d     = {word_q[15:0], in_data_i};
               csum_d     = csum_q ^ in_data_i;
               byte_cnt_d = byte_cnt_q + 2'd1;
               // Register the word on its last byte so it is visible throughout WR.
               if (byte_cnt_q == 2'd3) begin
                  addr_d  = BASE_ADDR + {14'd0, idx_q, 2'b00};
                  data_d  = {word_q, in_data_i};
                  state_d = StWr;
               end
            end
         end
         StWr: begin
            idx_d   = idx_inc[15:0];
            state_d = (idx_inc < {1'b0, n_q}) ? StData : PostLoadSt;
         end
         StChk: begin
            if (fire) begin
               state_d = (in_data_i == csum_q) ? StRun : StErr;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         n_q        <= '0;
         idx_q      <= '0;
         byte_cnt_q <= '0;
         word_q     <= '0;
         csum_q     <= '0;
         addr_q     <= BASE_ADDR;
         data_q     <= '0;
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         idx_q      <= idx_d;
         byte_cnt_q <= byte_cnt_d;
         word_q     <= word_d;
         csum_q     <= csum_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
      end
   end

   // A start in RUN re-asserts cpu reset combinationally in the same cycle.
   assign initialize_o = (state_q != StRun) || start_i;
   assign cpu_rst_o    = (state_q != StRun) || start_i;
   assign init_we_o    = (state_q == StWr);
   assign busy_o       = (state_q == StCnt) || (state_q == StData) || (state_q == StWr) ||
                         (state_q == StChk);
   assign done_o       = (state_q == StRun);
   assign error_o      = (state_q == StErr);
   assign instruction_initialize_address_o = addr_q;
   assign instruction_initialize_data_o    = data_q;

endmodule
